// File: rtl/prach_pkg.sv
//==============================================================================
// Module      : prach_pkg
// Description : Shared PRACH buffer constants and types (writer and readout).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package prach_pkg;

    localparam int HDR_W     = 120;
    localparam int N_SAMP    = 1536;
    localparam int RD_ADDR_W = 11;
    localparam int RD_LAT    = 2;

    typedef struct packed {
        logic [15:0] di;
        logic [15:0] dr;
    } prach_iq_t;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_st_t;

endpackage

`default_nettype wire

// File: rtl/prach_dpram.sv
//==============================================================================
// Module      : prach_dpram
// Description : Simple dual-port RAM, one write port, one registered read port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module prach_dpram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/prach_buffer_writer.sv
//==============================================================================
// Module      : prach_buffer_writer
// Description : Captures PRACH occasions into a ping-pong RAM and serves the
//               readout arbiter through the ap_req/ap_ack handshake.
//               Optional drop counter: define PRACH_BUF_DROP_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module prach_buffer_writer
    import prach_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          din_dr,
    input  logic [15:0]          din_di,
    input  logic                 din_dv,
    input  logic                 sync_in,
    input  logic [HDR_W-1:0]     hdr_in,
    output logic [HDR_W-1:0]     ap_hdr,
    output logic                 ap_req,
    input  logic                 ap_ack,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    input  logic                 rd_en,
    output logic [31:0]          rd_data,
    output logic                 drop,
    output logic [15:0]          drop_cnt
);

    localparam logic [0:0]           WR_IDLE   = 1'b0;
    localparam logic [0:0]           WR_WRITE  = 1'b1;
    localparam logic [RD_ADDR_W-1:0] LAST_ADDR = RD_ADDR_W'(N_SAMP - 1);

    bank_st_t               bank_q [2], bank_d [2];
    logic [HDR_W-1:0]       hdr_q [2], hdr_d [2];
    logic [0:0]             wr_st_q, wr_st_d;
    logic                   wr_bank_q, wr_bank_d;
    logic [RD_ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic                   old_q, old_d;
    logic                   req_q, req_d;
    logic                   rbank_q, rbank_d;
    logic [HDR_W-1:0]       ap_hdr_q, ap_hdr_d;
    logic                   ack_q;
    logic                   drop_q, drop_d;
    logic                   rd_ok_q;
    logic [31:0]            rd_data_q;

    logic                   w_sop, w_free_any, w_free_idx, w_grant, w_rd_ok;
    logic                   w_we, w_wbank;
    logic [RD_ADDR_W-1:0]   w_waddr_lo;
    prach_iq_t              w_wdata;
    logic [31:0]            w_ram_rdata;

    assign w_sop      = din_dv & sync_in;
    assign w_free_any = (bank_q[0] == BANK_FREE) || (bank_q[1] == BANK_FREE);
    assign w_free_idx = (bank_q[0] == BANK_FREE) ? 1'b0 : 1'b1;
    assign w_grant    = ap_ack & ~ack_q & req_q;
    assign w_wdata    = '{di: din_di, dr: din_dr};
    // The grant cycle itself may already carry a read, before the bank shows READING.
    assign w_rd_ok    = rd_en & ((bank_q[rbank_q] == BANK_READING) | w_grant);

    always_comb begin
        bank_d     = bank_q;
        hdr_d      = hdr_q;
        wr_st_d    = wr_st_q;
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        old_d      = old_q;
        req_d      = req_q;
        rbank_d    = rbank_q;
        ap_hdr_d   = ap_hdr_q;
        drop_d     = 1'b0;
        w_we       = 1'b0;
        w_wbank    = wr_bank_q;
        w_waddr_lo = wr_cnt_q;

        case (wr_st_q)
            WR_IDLE: begin
                if (w_sop) begin
                    if (w_free_any) begin
                        w_we              = 1'b1;
                        w_wbank           = w_free_idx;
                        w_waddr_lo        = '0;
                        wr_bank_d         = w_free_idx;
                        bank_d[w_free_idx] = BANK_FILLING;
                        hdr_d[w_free_idx] = hdr_in;
                        wr_cnt_d          = RD_ADDR_W'(1);
                        wr_st_d           = WR_WRITE;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: begin
                if (din_dv) begin
                    w_we = 1'b1;
                    if (sync_in) begin
                        w_waddr_lo       = '0;
                        hdr_d[wr_bank_q] = hdr_in;
                        wr_cnt_d         = RD_ADDR_W'(1);
                        drop_d           = 1'b1;
                    end else if (wr_cnt_q == LAST_ADDR) begin
                        bank_d[wr_bank_q] = BANK_FULL;
                        wr_st_d           = WR_IDLE;
                        wr_cnt_d          = '0;
                        // Order flag names the older FULL bank; keep it if the other is still waiting.
                        if (bank_q[~wr_bank_q] != BANK_FULL) begin
                            old_d = wr_bank_q;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt_q + RD_ADDR_W'(1);
                    end
                end
            end
        endcase

        if (w_grant) begin
            req_d           = 1'b0;
            bank_d[rbank_q] = BANK_READING;
        end else if (!ap_ack && (bank_q[rbank_q] == BANK_READING)) begin
            bank_d[rbank_q] = BANK_FREE;
        end

        if (!req_d && (bank_d[0] != BANK_READING) && (bank_d[1] != BANK_READING)) begin
            if (bank_d[old_d] == BANK_FULL) begin
                req_d    = 1'b1;
                rbank_d  = old_d;
                ap_hdr_d = hdr_q[old_d];
            end else if (bank_d[~old_d] == BANK_FULL) begin
                req_d    = 1'b1;
                rbank_d  = ~old_d;
                ap_hdr_d = hdr_q[~old_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= BANK_FREE;
            bank_q[1] <= BANK_FREE;
            wr_st_q   <= WR_IDLE;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            old_q     <= 1'b0;
            req_q     <= 1'b0;
            rbank_q   <= 1'b0;
            ap_hdr_q  <= '0;
            ack_q     <= 1'b0;
            drop_q    <= 1'b0;
            rd_ok_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            bank_q    <= bank_d;
            wr_st_q   <= wr_st_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            old_q     <= old_d;
            req_q     <= req_d;
            rbank_q   <= rbank_d;
            ap_hdr_q  <= ap_hdr_d;
            ack_q     <= ap_ack;
            drop_q    <= drop_d;
            rd_ok_q   <= w_rd_ok;
            // Zero when idle: all 24 writers share one OR-combined bus.
            rd_data_q <= rd_ok_q ? w_ram_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        hdr_q <= hdr_d;
    end

    prach_dpram #(
        .WIDTH (32),
        .DEPTH (4096)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (w_we),
        .wr_addr_i ({w_wbank, w_waddr_lo}),
        .wr_data_i (w_wdata),
        .rd_en_i   (w_rd_ok),
        .rd_addr_i ({rbank_q, rd_addr}),
        .rd_data_o (w_ram_rdata)
    );

`ifdef PRACH_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'd0;
`endif

    assign ap_req  = req_q;
    assign ap_hdr  = ap_hdr_q;
    assign drop    = drop_q;
    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_prach_buffer_writer.sv
//==============================================================================
// Module      : tb_prach_buffer_writer
// Description : Randomized self-checking bench for prach_buffer_writer.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prach_buffer_writer;
    import prach_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [15:0]          din_dr = '0, din_di = '0;
    logic                 din_dv = 1'b0, sync_in = 1'b0;
    logic [HDR_W-1:0]     hdr_in = '0;
    logic [HDR_W-1:0]     ap_hdr;
    logic                 ap_req;
    logic                 ap_ack = 1'b0;
    logic [RD_ADDR_W-1:0] rd_addr = '0;
    logic                 rd_en = 1'b0;
    logic [31:0]          rd_data;
    logic                 drop;
    logic [15:0]          drop_cnt;

    always #5 clk = ~clk;

    prach_buffer_writer dut (
        .clk(clk), .rst(rst), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .hdr_in(hdr_in), .ap_hdr(ap_hdr), .ap_req(ap_req),
        .ap_ack(ap_ack), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .drop(drop), .drop_cnt(drop_cnt)
    );

    int n_checks = 0, n_errors = 0;
    int drop_seen = 0, exp_drops = 0, n_busy = 0;
    bit reading = 1'b0;
    logic [HDR_W-1:0] q_hdr [$];
    logic [31:0]      q_base [$];

    always @(negedge clk) if (drop === 1'b1) drop_seen++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] base, input int k);
        logic [15:0] dr;
        dr = 16'(k) ^ base[15:0];
        return {~dr ^ base[31:16], dr};
    endfunction

    function automatic logic [HDR_W-1:0] rand_hdr();
        return HDR_W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic chk_dcnt(input string tag);
`ifdef PRACH_BUF_DROP_CNT_EN
        chk(tag, 128'(drop_cnt), 128'(exp_drops));
`else
        chk(tag, 128'(drop_cnt), 128'd0);
`endif
    endtask

    // Model view: the oldest completed occasion is offered unless one is being read.
    task automatic chk_offer(input string tag);
        if (!reading && q_hdr.size() > 0) begin
            chk({tag, "_req"}, 128'(ap_req), 128'd1);
            chk({tag, "_hdr"}, 128'(ap_hdr), 128'(q_hdr[0]));
        end else begin
            chk({tag, "_req"}, 128'(ap_req), 128'd0);
        end
    endtask

    task automatic send_samples(input logic [HDR_W-1:0] hdr, input logic [31:0] base,
                                input int k0, input int k1, input bit do_sync);
        logic [31:0] w;
        for (int k = k0; k < k1; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                din_dv  = 1'b0;
                sync_in = 1'($urandom_range(0, 1));
                din_dr  = 16'($urandom);
                din_di  = 16'($urandom);
                hdr_in  = rand_hdr();
                step();
            end
            w       = exp_word(base, k);
            din_dv  = 1'b1;
            sync_in = do_sync && (k == k0);
            din_dr  = w[15:0];
            din_di  = w[31:16];
            hdr_in  = (do_sync && (k == k0)) ? hdr : rand_hdr();
            step();
        end
        din_dv  = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic occasion(input logic [HDR_W-1:0] hdr, input logic [31:0] base, input int lead);
        int d0;
        bit acc;
        d0  = drop_seen;
        acc = (n_busy < 2);
        repeat (lead) step();
        send_samples(hdr, base, 0, N_SAMP, 1'b1);
        chk("occ_drop", 128'(drop_seen - d0), acc ? 128'd0 : 128'd1);
        if (acc) begin
            n_busy++;
            q_hdr.push_back(hdr);
            q_base.push_back(base);
        end else begin
            exp_drops++;
        end
        chk_offer("occ");
    endtask

    task automatic grant_read(input int ncyc);
        logic [31:0] base, cur, prev;
        bit en;
        int a;
        chk("gnt_req", 128'(ap_req), 128'd1);
        chk("gnt_hdr", 128'(ap_hdr), 128'(q_hdr[0]));
        base = q_base[0];
        void'(q_hdr.pop_front());
        void'(q_base.pop_front());
        reading = 1'b1;
        prev    = '0;
        ap_ack  = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            en      = (i == 0) || ($urandom_range(0, 3) != 0);
            a       = (i == 0) ? 5 : $urandom_range(0, N_SAMP - 1);
            rd_en   = en;
            rd_addr = RD_ADDR_W'(a);
            cur     = en ? exp_word(base, a) : 32'd0;
            step();
            if (i == 0) chk("ack_req_clr", 128'(ap_req), 128'd0);
            else        chk("rd_data", 128'(rd_data), 128'(prev));
            prev = cur;
        end
        ap_ack  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = RD_ADDR_W'($urandom);
        step();
        chk("rd_data_tail", 128'(rd_data), 128'(prev));
        reading = 1'b0;
        n_busy--;
        chk_offer("rel");
        step();
        chk("rd_data_idle", 128'(rd_data), 128'd0);
    endtask

    initial begin
        logic [HDR_W-1:0] h_e, h_f;
        logic [31:0]      b_f, b_g;
        int               d0;

        step();
        step();
        chk("rst_req", 128'(ap_req), 128'd0);
        chk("rst_hdr", 128'(ap_hdr), 128'd0);
        chk("rst_rd", 128'(rd_data), 128'd0);
        chk("rst_drop", 128'(drop), 128'd0);
        chk("rst_dcnt", 128'(drop_cnt), 128'd0);
        rst = 1'b0;
        step();

        // Single ramp occasion, ap_req timing around the last sample
        send_samples(120'hABC, 32'd0, 0, N_SAMP - 1, 1'b1);
        chk("t1_req_early", 128'(ap_req), 128'd0);
        send_samples(120'hABC, 32'd0, N_SAMP - 1, N_SAMP, 1'b0);
        n_busy++;
        q_hdr.push_back(120'hABC);
        q_base.push_back(32'd0);
        chk_offer("t1");
        chk("t1_drop", 128'(drop_seen), 128'd0);
        grant_read(N_SAMP);

        // Ping-pong overflow and oldest-first ordering
        occasion(rand_hdr(), $urandom, 0);
        occasion(rand_hdr(), $urandom, 0);
        occasion(rand_hdr(), $urandom, 0);
        chk_dcnt("ovf_dcnt");
        grant_read(200);
        fork
            grant_read(N_SAMP);
            occasion(rand_hdr(), $urandom, 10);
        join
        grant_read(300);

        // Abort at sample 700
        h_e = rand_hdr();
        h_f = rand_hdr();
        b_f = $urandom;
        d0  = drop_seen;
        send_samples(h_e, $urandom, 0, 700, 1'b1);
        chk("abort_req_pre", 128'(ap_req), 128'd0);
        send_samples(h_f, b_f, 0, N_SAMP, 1'b1);
        chk("abort_drop", 128'(drop_seen - d0), 128'd1);
        exp_drops++;
        n_busy++;
        q_hdr.push_back(h_f);
        q_base.push_back(b_f);
        chk_offer("abort");
        chk_dcnt("abort_dcnt");
        grant_read(400);

        // OR-bus hygiene: idle reads and ack without request
        for (int i = 0; i < 30; i++) begin
            rd_en   = 1'b0;
            rd_addr = RD_ADDR_W'($urandom);
            step();
            chk("or_idle", 128'(rd_data), 128'd0);
        end
        ap_ack = 1'b1;
        rd_en  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rd_addr = RD_ADDR_W'($urandom_range(0, N_SAMP - 1));
            step();
            chk("or_noreq", 128'(rd_data), 128'd0);
        end
        chk("or_noreq_req", 128'(ap_req), 128'd0);
        ap_ack = 1'b0;
        rd_en  = 1'b0;
        step();

        // Reset in the middle of a readout
        b_g = $urandom;
        occasion(rand_hdr(), b_g, 0);
        ap_ack  = 1'b1;
        rd_en   = 1'b1;
        rd_addr = RD_ADDR_W'(5);
        step();
        chk("rst_pre_req", 128'(ap_req), 128'd0);
        step();
        chk("rst_pre_data", 128'(rd_data), 128'(exp_word(b_g, 5)));
        rst = 1'b1;
        step();
        chk("mid_rst_req", 128'(ap_req), 128'd0);
        chk("mid_rst_rd", 128'(rd_data), 128'd0);
        chk("mid_rst_hdr", 128'(ap_hdr), 128'd0);
        chk("mid_rst_drop", 128'(drop), 128'd0);
        chk("mid_rst_dcnt", 128'(drop_cnt), 128'd0);
        rst    = 1'b0;
        ap_ack = 1'b0;
        rd_en  = 1'b0;
        q_hdr.delete();
        q_base.delete();
        n_busy    = 0;
        reading   = 1'b0;
        exp_drops = 0;
        step();
        occasion(rand_hdr(), $urandom, 0);
        occasion(rand_hdr(), $urandom, 0);
        occasion(rand_hdr(), $urandom, 0);
        chk_dcnt("post_rst_dcnt");
        grant_read(200);
        grant_read(200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
